// File: rtl/rr_arbiter_if.sv
// rtl/rr_arbiter_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface rr_arbiter_if #(
  parameter int REQCNT   = 3,
  parameter int REQWIDTH = $clog2(REQCNT)
);
  logic [REQCNT-1:0]   req_i;
  logic [REQCNT-1:0]   gnt_o;
  logic [REQWIDTH-1:0] gnt_num_o;
  logic                gnt_valid_o;
  logic [REQWIDTH-1:0] prior_o;

  modport master (
    output req_i,
    input  gnt_o, gnt_num_o, gnt_valid_o, prior_o
  );

  modport slave (
    input  req_i,
    output gnt_o, gnt_num_o, gnt_valid_o, prior_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered grant and optional hold-time limit
module rr_arbiter #(
  parameter int REQCNT   = 3,
  parameter int REQWIDTH = $clog2(REQCNT),
  parameter int MAX_HOLD = 8,
  parameter int CNTWIDTH = $clog2(MAX_HOLD + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  rr_arbiter_if.slave  bus
);
  // With MAX_HOLD=0 the natural counter width is zero; keep one saturating bit.
  localparam int CW = (CNTWIDTH < 1) ? 1 : CNTWIDTH;
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e              state_q, state_d;
  logic [REQCNT-1:0]   gnt_q, gnt_d;
  logic [REQWIDTH-1:0] gnt_num_q, gnt_num_d;
  logic [REQWIDTH-1:0] prior_q, prior_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                grant_end;
  logic [REQWIDTH-1:0] rot_ptr;
  logic [REQWIDTH-1:0] search_ptr;
  logic [REQWIDTH:0]   search_res;
  logic                win_valid;
  logic [REQWIDTH-1:0] win_idx;

  // Scan ptr, ptr+1, ... wrapping at REQCNT; descending loop so the nearest hit is kept.
  function automatic logic [REQWIDTH:0] find_winner(input logic [REQCNT-1:0] req,
                                                     input logic [REQWIDTH-1:0] ptr);
    logic [REQWIDTH:0] res;
    int                idx;
    res = '0;
    for (int k = REQCNT - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= REQCNT) idx = idx - REQCNT;
      if (req[idx[REQWIDTH-1:0]]) res = {1'b1, idx[REQWIDTH-1:0]};
    end
    return res;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_num_q <= '0;
      prior_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_num_q <= gnt_num_d;
      prior_q   <= prior_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    grant_end  = (state_q == GRANT) &&
                 (!bus.req_i[gnt_num_q] || ((MAX_HOLD != 0) && (cnt_q == HOLD_LAST)));
    rot_ptr    = (gnt_num_q == REQWIDTH'(REQCNT - 1)) ? '0 : gnt_num_q + REQWIDTH'(1);
    // The rotated pointer feeds the search in the same cycle so handover has no gap.
    search_ptr = grant_end ? rot_ptr : prior_q;
    search_res = find_winner(bus.req_i, search_ptr);
    win_valid  = search_res[REQWIDTH];
    win_idx    = search_res[REQWIDTH-1:0];

    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = GRANT;
      GRANT:   if (grant_end) state_d = win_valid ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d     = gnt_q;
    gnt_num_d = gnt_num_q;
    cnt_d     = cnt_q;
    prior_d   = grant_end ? rot_ptr : prior_q;
    if (((state_q == IDLE) || grant_end) && win_valid) begin
      gnt_num_d = win_idx;
      gnt_d     = REQCNT'(1) << win_idx;
      cnt_d     = '0;
    end else if ((state_q == IDLE) || grant_end) begin
      gnt_num_d = '0;
      gnt_d     = '0;
      cnt_d     = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_num_o   = gnt_num_q;
  assign bus.gnt_valid_o = (state_q == GRANT);
  assign bus.prior_o     = prior_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - scoreboard bench for rr_arbiter: directed sequences plus a random sweep
module tb_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_arbiter_if #(.REQCNT(3)) ifa ();
  rr_arbiter_if #(.REQCNT(3)) ifb ();
  rr_arbiter_if #(.REQCNT(5)) ifc ();

  rr_arbiter #(.REQCNT(3), .MAX_HOLD(8)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa.slave));
  rr_arbiter #(.REQCNT(3), .MAX_HOLD(4)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb.slave));
  rr_arbiter #(.REQCNT(5), .MAX_HOLD(0)) dut_c (.clk_i(clk), .rst_i(rst), .bus(ifc.slave));

  typedef struct packed {
    logic [2:0] gnt;
    logic [1:0] num;
    logic       v;
    logic [1:0] prior;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  function automatic exp_t mk(input logic [2:0] g, input logic [1:0] n, input logic v,
                              input logic [1:0] p);
    return {g, n, v, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] rq [8];
    exp_t       ex [8];
    exp_t       got, e;
    got = {ifa.gnt_o, ifa.gnt_num_o, ifa.gnt_valid_o, ifa.prior_o};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL reset_a got=%h exp=00", got);
    end
    checks++;
    if ({ifc.gnt_o, ifc.gnt_num_o, ifc.gnt_valid_o, ifc.prior_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_c got gnt=%b num=%0d v=%b prior=%0d exp all zero",
               ifc.gnt_o, ifc.gnt_num_o, ifc.gnt_valid_o, ifc.prior_o);
    end
    rst = 1'b0;
    rq = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b010};
    ex = '{mk(3'b000, 0, 0, 0), mk(3'b000, 0, 0, 0), mk(3'b000, 0, 0, 0), mk(3'b000, 0, 0, 0),
           mk(3'b000, 0, 0, 0), mk(3'b001, 0, 1, 0), mk(3'b000, 0, 0, 1), mk(3'b010, 1, 1, 1)};
    for (int k = 0; k < 8; k++) begin
      ifa.req_i = rq[k];
      sb.push_back(ex[k]);
      tick();
      got = {ifa.gnt_o, ifa.gnt_num_o, ifa.gnt_valid_o, ifa.prior_o};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_seq step %0d got gnt=%b num=%0d v=%b prior=%0d exp gnt=%b num=%0d v=%b prior=%0d",
                 k, got.gnt, got.num, got.v, got.prior, e.gnt, e.num, e.v, e.prior);
      end
    end
    // Mid-grant reset must clear outputs with no clock edge in between.
    #2 rst = 1'b1;
    #1;
    got = {ifa.gnt_o, ifa.gnt_num_o, ifa.gnt_valid_o, ifa.prior_o};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got=%h exp=00", got);
    end
    ifa.req_i = 3'b000;
    #2 rst = 1'b0;
  endtask

  task automatic test_all_requesting();
    logic [2:0] rq [14];
    exp_t       ex [14];
    exp_t       got, e;
    rq = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011,
           3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011, 3'b000};
    ex = '{mk(3'b001, 0, 1, 0), mk(3'b001, 0, 1, 0), mk(3'b010, 1, 1, 1), mk(3'b010, 1, 1, 1),
           mk(3'b100, 2, 1, 2), mk(3'b100, 2, 1, 2), mk(3'b001, 0, 1, 0), mk(3'b001, 0, 1, 0),
           mk(3'b010, 1, 1, 1), mk(3'b010, 1, 1, 1), mk(3'b100, 2, 1, 2), mk(3'b100, 2, 1, 2),
           mk(3'b001, 0, 1, 0), mk(3'b000, 0, 0, 1)};
    for (int k = 0; k < 14; k++) begin
      ifa.req_i = rq[k];
      sb.push_back(ex[k]);
      tick();
      got = {ifa.gnt_o, ifa.gnt_num_o, ifa.gnt_valid_o, ifa.prior_o};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL all_req step %0d got gnt=%b num=%0d v=%b prior=%0d exp gnt=%b num=%0d v=%b prior=%0d",
                 k, got.gnt, got.num, got.v, got.prior, e.gnt, e.num, e.v, e.prior);
      end
    end
  endtask

  task automatic test_single_request();
    logic [2:0] rq [6];
    exp_t       ex [6];
    exp_t       got, e;
    rq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
    ex = '{mk(3'b100, 2, 1, 1), mk(3'b100, 2, 1, 1), mk(3'b100, 2, 1, 1), mk(3'b100, 2, 1, 1),
           mk(3'b000, 0, 0, 0), mk(3'b000, 0, 0, 0)};
    for (int k = 0; k < 6; k++) begin
      ifa.req_i = rq[k];
      sb.push_back(ex[k]);
      tick();
      got = {ifa.gnt_o, ifa.gnt_num_o, ifa.gnt_valid_o, ifa.prior_o};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL single step %0d got gnt=%b num=%0d v=%b prior=%0d exp gnt=%b num=%0d v=%b prior=%0d",
                 k, got.gnt, got.num, got.v, got.prior, e.gnt, e.num, e.v, e.prior);
      end
    end
  endtask

  task automatic test_pointer_priority();
    logic [2:0] rq [5];
    exp_t       ex [5];
    exp_t       got, e;
    rq = '{3'b010, 3'b000, 3'b011, 3'b010, 3'b000};
    ex = '{mk(3'b010, 1, 1, 0), mk(3'b000, 0, 0, 2), mk(3'b001, 0, 1, 2), mk(3'b010, 1, 1, 1),
           mk(3'b000, 0, 0, 2)};
    for (int k = 0; k < 5; k++) begin
      ifa.req_i = rq[k];
      sb.push_back(ex[k]);
      tick();
      got = {ifa.gnt_o, ifa.gnt_num_o, ifa.gnt_valid_o, ifa.prior_o};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL pointer step %0d got gnt=%b num=%0d v=%b prior=%0d exp gnt=%b num=%0d v=%b prior=%0d",
                 k, got.gnt, got.num, got.v, got.prior, e.gnt, e.num, e.v, e.prior);
      end
    end
  endtask

  task automatic test_timeout();
    logic [2:0] rq;
    exp_t       e, got;
    for (int k = 0; k < 23; k++) begin
      if (k < 13)       rq = 3'b011;
      else if (k < 22)  rq = 3'b001;
      else              rq = 3'b000;
      if (k < 4)        e = mk(3'b001, 0, 1, 0);
      else if (k < 8)   e = mk(3'b010, 1, 1, 1);
      else if (k < 12)  e = mk(3'b001, 0, 1, 2);
      else if (k == 12) e = mk(3'b010, 1, 1, 1);
      else if (k < 17)  e = mk(3'b001, 0, 1, 2);
      else if (k < 22)  e = mk(3'b001, 0, 1, 1);
      else              e = mk(3'b000, 0, 0, 1);
      ifb.req_i = rq;
      sb.push_back(e);
      tick();
      got = {ifb.gnt_o, ifb.gnt_num_o, ifb.gnt_valid_o, ifb.prior_o};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL timeout step %0d got gnt=%b num=%0d v=%b prior=%0d exp gnt=%b num=%0d v=%b prior=%0d",
                 k, got.gnt, got.num, got.v, got.prior, e.gnt, e.num, e.v, e.prior);
      end
    end
  endtask

  task automatic test_sweep();
    logic [4:0] r;
    int         waits [5];
    logic       prev_v;
    logic [2:0] prev_n;
    r = '0;
    prev_v = 1'b0;
    prev_n = '0;
    for (int i = 0; i < 5; i++) waits[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      ifc.req_i = r;
      tick();
      checks++;
      if (!$onehot0(ifc.gnt_o) || (ifc.gnt_valid_o !== (|ifc.gnt_o)) ||
          (ifc.gnt_valid_o && (ifc.gnt_o !== (5'b00001 << ifc.gnt_num_o))) ||
          (!ifc.gnt_valid_o && (ifc.gnt_num_o !== 3'd0))) begin
        errors++;
        $display("FAIL sweep_invariant cycle %0d got gnt=%b num=%0d v=%b", cyc,
                 ifc.gnt_o, ifc.gnt_num_o, ifc.gnt_valid_o);
      end
      if (prev_v && r[prev_n]) begin
        checks++;
        if (!(ifc.gnt_valid_o === 1'b1 && ifc.gnt_num_o === prev_n)) begin
          errors++;
          $display("FAIL sweep_preempt cycle %0d got num=%0d v=%b exp num=%0d v=1", cyc,
                   ifc.gnt_num_o, ifc.gnt_valid_o, prev_n);
        end
      end
      if (ifc.gnt_valid_o && (!prev_v || ifc.gnt_num_o != prev_n)) begin
        for (int i = 0; i < 5; i++) begin
          if (ifc.gnt_num_o == i) begin
            checks++;
            if (waits[i] > 4) begin
              errors++;
              $display("FAIL sweep_fairness cycle %0d req %0d waited %0d grants exp <= 4",
                       cyc, i, waits[i]);
            end
            waits[i] = 0;
          end else if (r[i]) begin
            waits[i]++;
          end
        end
      end
      for (int i = 0; i < 5; i++) if (!r[i]) waits[i] = 0;
      prev_v = ifc.gnt_valid_o;
      prev_n = ifc.gnt_num_o;
      // Requesters hold until served; the owner releases at random.
      for (int i = 0; i < 5; i++) begin
        if (r[i]) begin
          if (ifc.gnt_valid_o && ifc.gnt_num_o == i && $urandom_range(2) == 0) r[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          r[i] = 1'b1;
        end
      end
    end
    ifc.req_i = '0;
    tick();
    tick();
  endtask

  initial begin
    ifa.req_i = '0;
    ifb.req_i = '0;
    ifc.req_i = '0;
    #12;
    test_reset();
    test_all_requesting();
    test_single_request();
    test_pointer_priority();
    test_timeout();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
Round-robin arbiter that shares one downstream resource between REQCNT requesters. It holds a registered grant until the owner releases its request or a hold-time limit expires. Priority then rotates to the requester after the last owner, giving fair access. It sits in front of the shared datapath and drives its select, both as a one-hot vector and as a binary index.

Parameters:
REQCNT, 3, number of requesters (>=2, need not be a power of 2)
REQWIDTH, $clog2(REQCNT), width of index/pointer signals
MAX_HOLD, 8, max consecutive grant cycles per ownership; 0 = unlimited
CNTWIDTH, $clog2(MAX_HOLD+1), width of hold counter

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst_i  input  1  reset, asynchronous, active-high
req_i  input  REQCNT  request vector, bit i = requester i; level, held until done
gnt_o  output  REQCNT  registered one-hot grant; all-zero when idle
gnt_num_o  output  REQWIDTH  registered index of current owner; 0 when idle
gnt_valid_o  output  1  registered, high while any grant active
prior_o  output  REQWIDTH  current round-robin pointer (debug/visibility)

Behaviour:
- Reset (async assert, sync-safe release):
  - gnt_o=0, gnt_num_o=0, gnt_valid_o=0, prior_o=0
  - hold counter=0, state=IDLE
  - Reset mid-grant drops the grant immediately, with no completion.
- Winner search (combinational):
  - Scan indices prior, prior+1, … modulo REQCNT, wrapping at REQCNT (not 2^REQWIDTH).
  - First index with req_i set wins.
  - No request means no winner.
- State IDLE:
  - If any req_i bit is set: register the winner into gnt_o/gnt_num_o, set gnt_valid_o=1, clear hold counter, go to GRANT.
  - Latency: req asserted in cycle N gives grant visible in cycle N+1.
  - Otherwise stay in IDLE, outputs zero.
- State GRANT (owner = gnt_num_o): hold counter increments every GRANT cycle; saturates if MAX_HOLD=0. The grant ends when either:
  - (a) req_i[owner]==0 (release), or
  - (b) MAX_HOLD!=0 and hold counter == MAX_HOLD-1 (timeout). The owner then holds exactly MAX_HOLD cycles.
- On grant end in cycle N:
  - prior is set to (owner+1) mod REQCNT.
  - The winner search uses this new pointer in the same cycle.
  - If a winner exists, it is granted in cycle N+1 with no idle gap, and the hold counter is cleared.
  - If no winner exists, outputs clear in N+1 and the state goes to IDLE.
- Timeout with the owner as sole requester: the owner is re-granted (the search wraps back to it) and the counter restarts. gnt_o stays high continuously.
- Non-owner request changes during GRANT have no effect until grant end.
- Owner request re-asserted after release competes normally from the new pointer; no back-to-back win over other pending requesters.
- Invariants: gnt_o is always one-hot or zero; gnt_o==(1<<gnt_num_o) when gnt_valid_o==1; gnt_valid_o==|gnt_o.
- Simultaneous requests in IDLE are resolved by the pointer alone; the lowest index does not win unless it is the first at or after the pointer.
- prior_o changes only at grant end. It is never updated in IDLE and never on a grant start.

Test Plan:
- Reset, then req_i=3'b000 for 5 cycles -> gnt_o=0, gnt_valid_o=0, prior_o=0 throughout. Assert rst_i mid-GRANT -> outputs 0 without waiting for a clock edge.
- All requesting: req_i=3'b111 held, MAX_HOLD=8, each owner drops its req after 2 grant cycles and re-raises it next cycle.
  - Required grant order: 0,1,2,0,1,2, with no idle cycles between owners.
  - prior_o steps 1,2,0,1.
- Single request: req_i=3'b100 in cycle 0 -> gnt_o=3'b100, gnt_num_o=2 in cycle 1. Drop req in cycle 4 -> gnt_o=0 in cycle 5, prior_o=0 (wrap from 2).
- Timeout, MAX_HOLD=4:
  - req_i=3'b011 held, prior=0 -> owner 0 for exactly 4 cycles, then owner 1 for 4 cycles, then owner 0.
  - Sole requester 3'b001 held -> gnt_o stays 3'b001 continuously, and the counter restarts every 4 cycles.
- Pointer priority: with prior_o=2 and req_i=3'b011 arriving in IDLE -> grant goes to 0, not 1. After 0 releases with req 1 pending -> grant goes to 1 the next cycle.
- Parameter sweep: REQCNT=5, MAX_HOLD=0, random req for 10k cycles.
  - Check the invariants every cycle.
  - No requester that requests continuously waits more than REQCNT-1 other grants.
  - No grant is ever preempted while its owner keeps requesting.
